// File: rtl/bankbuff_feeder.sv
// Row sequencer feeding the bank buffer from image SRAM and presenting
// completed vertical windows to the MAC array, left strip then right strip.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start
//   CLR    | clear bank buffer, reset pushed-row count
//   RD     | issue SRAM read for strip*IMG_ROWS+row
//   PUSH   | shift returned row into bank buffer
//   WIN    | window complete and frozen until win_ready
//   DONE   | one-cycle frame-complete pulse
module bankbuff_feeder #(
   parameter int FXP          = 6,
   parameter int BB_REG_WIDTH = 36,
   parameter int MAC_CN_HGT   = 5,
   parameter int IMG_ROWS     = 32,
   parameter int ADDR_W       = 10
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             mem_rd_en,
   output logic [ADDR_W-1:0]                mem_addr,
   input  logic [BB_REG_WIDTH*FXP-1:0]      mem_rd_data,
   output logic                             bb_en,
   output logic                             bb_clr,
   output logic [BB_REG_WIDTH*FXP-1:0]      bb_val_in,
   output logic                             bb_roi_lb_r,
   output logic                             win_valid,
   input  logic                             win_ready,
   output logic [$clog2(IMG_ROWS)-1:0]      win_row
);

   localparam int RW = $clog2(IMG_ROWS);
   localparam int CW = $clog2(MAC_CN_HGT + 1);
   localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_ROWS - 1);
   localparam logic [RW-1:0]     WIN_OFS    = RW'(MAC_CN_HGT - 1);
   localparam logic [CW-1:0]     CNT_FULL   = CW'(MAC_CN_HGT);
   localparam logic [ADDR_W-1:0] STRIP_BASE = ADDR_W'(IMG_ROWS);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_RD, S_PUSH, S_WIN, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            strip_q, strip_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_inc;

   assign cnt_inc = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         strip_q <= 1'b0;
         row_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         strip_q <= strip_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      strip_d = strip_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLR;
               strip_d = 1'b0;
               row_d   = '0;
            end
         end
         S_CLR: begin
            cnt_d   = '0;
            state_d = S_RD;
         end
         S_RD: state_d = S_PUSH;
         S_PUSH: begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
               state_d = S_WIN;
            end else begin
               row_d   = row_q + RW'(1);
               state_d = S_RD;
            end
         end
         S_WIN: begin
            if (win_ready) begin
               if (row_q != ROW_LAST) begin
                  row_d   = row_q + RW'(1);
                  state_d = S_RD;
               end else if (!strip_q) begin
                  strip_d = 1'b1;
                  row_d   = '0;
                  state_d = S_CLR;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs; everything data-bearing is forced to zero outside its state
   always_comb begin
      busy        = (state_q != S_IDLE);
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_addr    = '0;
      bb_en       = 1'b0;
      bb_clr      = 1'b0;
      bb_val_in   = '0;
      win_valid   = 1'b0;
      win_row     = '0;
      bb_roi_lb_r = strip_q;
      case (state_q)
         S_CLR:  bb_clr = 1'b1;
         S_RD: begin
            mem_rd_en = 1'b1;
            mem_addr  = (strip_q ? STRIP_BASE : '0) + ADDR_W'(row_q);
         end
         S_PUSH: begin
            bb_en     = 1'b1;
            bb_val_in = mem_rd_data;
         end
         S_WIN: begin
            win_valid = 1'b1;
            win_row   = row_q - WIN_OFS;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bankbuff_feeder.sv
// Directed bench for bankbuff_feeder: default geometry plus a 5-row instance.
module tb_bankbuff_feeder;

   localparam int DW = 36 * 6;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            win_ready = 1'b1;
   logic            busy, done, mem_rd_en, bb_en, bb_clr, bb_roi_lb_r, win_valid;
   logic [9:0]      mem_addr;
   logic [DW-1:0]   mem_rd_data = '0;
   logic [DW-1:0]   bb_val_in;
   logic [4:0]      win_row;

   logic            start5 = 1'b0;
   logic            busy5, done5, rd5, bb_en5, bb_clr5, roi5, wv5;
   logic [9:0]      addr5;
   logic [DW-1:0]   data5 = '0;
   logic [DW-1:0]   val5;
   logic [2:0]      wr5;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bankbuff_feeder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .bb_en(bb_en), .bb_clr(bb_clr), .bb_val_in(bb_val_in),
      .bb_roi_lb_r(bb_roi_lb_r), .win_valid(win_valid), .win_ready(win_ready),
      .win_row(win_row)
   );

   bankbuff_feeder #(.IMG_ROWS(5), .MAC_CN_HGT(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .busy(busy5), .done(done5),
      .mem_rd_en(rd5), .mem_addr(addr5), .mem_rd_data(data5),
      .bb_en(bb_en5), .bb_clr(bb_clr5), .bb_val_in(val5),
      .bb_roi_lb_r(roi5), .win_valid(wv5), .win_ready(1'b1),
      .win_row(wr5)
   );

   function automatic logic [DW-1:0] pat(input logic [9:0] a);
      return {a, 196'd0, ~a};
   endfunction

   // SRAM models: data one cycle after the read strobe, all-ones otherwise
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? pat(mem_addr) : {DW{1'b1}};
      data5       <= rd5 ? pat(addr5) : {DW{1'b1}};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; start5 = 1'b0; win_ready = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      logic [DW+20:0] outs;
      outs = {busy, done, mem_rd_en, mem_addr, bb_en, bb_clr, bb_val_in,
              bb_roi_lb_r, win_valid, win_row};
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL %s: outputs got %0h required 0", name, outs);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; win_ready = 1'b1;
      tick();
      check_all_zero("reset_outputs");
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_full_frame();
      int exp_addr = 0, last_addr = 0, exp_wr = 0;
      int wins0 = 0, wins1 = 0, clr_cnt = 0, done_cyc = -1, first_win = -1;
      logic [DW-1:0] exp_val;
      do_reset();
      start_frame();
      for (int c = 1; c <= 190; c++) begin
         if (mem_rd_en) begin
            n_checks++;
            if (mem_addr !== 10'(exp_addr)) begin
               n_fail++;
               $display("FAIL addr_order c=%0d: got %0d required %0d", c, mem_addr, exp_addr);
            end
            last_addr = exp_addr;
            exp_addr++;
         end
         exp_val = bb_en ? pat(10'(last_addr)) : '0;
         n_checks++;
         if (bb_val_in !== exp_val) begin
            n_fail++;
            $display("FAIL bb_val_in c=%0d: got %0h required %0h", c, bb_val_in, exp_val);
         end
         if (bb_clr) begin
            clr_cnt++;
            exp_wr = 0;
            n_checks++;
            if (c != 1 && c != 94) begin
               n_fail++;
               $display("FAIL clr_cycle: got %0d required 1 or 94", c);
            end
         end
         if (win_valid) begin
            if (first_win < 0) first_win = c;
            n_checks++;
            if (win_row !== 5'(exp_wr)) begin
               n_fail++;
               $display("FAIL win_row c=%0d: got %0d required %0d", c, win_row, exp_wr);
            end
            exp_wr++;
            if (bb_roi_lb_r) wins1++; else wins0++;
         end
         n_checks++;
         if (bb_roi_lb_r !== (c >= 94)) begin
            n_fail++;
            $display("FAIL roi c=%0d: got %0b required %0b", c, bb_roi_lb_r, c >= 94);
         end
         n_checks++;
         if (busy !== (c <= 187)) begin
            n_fail++;
            $display("FAIL busy c=%0d: got %0b required %0b", c, busy, c <= 187);
         end
         if (done) begin
            if (done_cyc < 0) done_cyc = c;
            else begin
               n_checks++; n_fail++;
               $display("FAIL done_twice: got cycle %0d required single pulse", c);
            end
         end
         tick();
      end
      n_checks++;
      if (exp_addr != 64) begin
         n_fail++; $display("FAIL read_count: got %0d required 64", exp_addr);
      end
      n_checks++;
      if (wins0 != 28 || wins1 != 28) begin
         n_fail++; $display("FAIL window_count: got %0d/%0d required 28/28", wins0, wins1);
      end
      n_checks++;
      if (clr_cnt != 2) begin
         n_fail++; $display("FAIL clr_count: got %0d required 2", clr_cnt);
      end
      n_checks++;
      if (done_cyc != 187) begin
         n_fail++; $display("FAIL done_cycle: got %0d required 187", done_cyc);
      end
      n_checks++;
      if (first_win != 12) begin
         n_fail++; $display("FAIL first_window: got %0d required 12", first_win);
      end
   endtask

   task automatic test_backpressure();
      bit found = 0, saw_done = 0;
      do_reset();
      start_frame();
      for (int i = 0; i < 100 && !found; i++) begin
         if (win_valid && win_row == 5'd3) found = 1;
         else tick();
      end
      n_checks++;
      if (!found) begin
         n_fail++; $display("FAIL bp_find_window: got none required win_row 3");
      end
      win_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({win_valid, win_row, bb_en, mem_rd_en} !== {1'b1, 5'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold i=%0d: got %b required %b", i,
                     {win_valid, win_row, bb_en, mem_rd_en}, {1'b1, 5'd3, 1'b0, 1'b0});
         end
         tick();
      end
      win_ready = 1'b1;
      tick();
      n_checks++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 10'd8) begin
         n_fail++;
         $display("FAIL bp_resume: got rd=%0b addr=%0d required rd=1 addr=8", mem_rd_en, mem_addr);
      end
      for (int i = 0; i < 300 && !saw_done; i++) begin
         if (done) saw_done = 1;
         tick();
      end
      n_checks++;
      if (!saw_done) begin
         n_fail++; $display("FAIL bp_done: got no done required done");
      end
   endtask

   task automatic test_reset_mid();
      bit saw_done = 0, saw_busy = 0;
      do_reset();
      start_frame();
      for (int c = 1; c < 50; c++) tick();
      rst_n = 1'b0;
      tick();
      check_all_zero("mid_reset_outputs");
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (done) saw_done = 1;
         if (busy) saw_busy = 1;
         tick();
      end
      n_checks++;
      if (saw_done || saw_busy) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: got done=%0b busy=%0b required 0/0", saw_done, saw_busy);
      end
      start_frame();
      n_checks++;
      if (bb_clr !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL restart_clr: got clr=%0b busy=%0b required 1/1", bb_clr, busy);
      end
      tick();
      n_checks++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 10'd0) begin
         n_fail++;
         $display("FAIL restart_addr: got rd=%0b addr=%0d required rd=1 addr=0", mem_rd_en, mem_addr);
      end
   endtask

   task automatic test_start_while_busy();
      int exp_addr = 0, done_cyc = -1;
      do_reset();
      start_frame();
      for (int c = 1; c <= 188; c++) begin
         if (mem_rd_en) begin
            n_checks++;
            if (mem_addr !== 10'(exp_addr)) begin
               n_fail++;
               $display("FAIL busy_start_addr c=%0d: got %0d required %0d", c, mem_addr, exp_addr);
            end
            exp_addr++;
         end
         if (done && done_cyc < 0) done_cyc = c;
         if (c == 188) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++; $display("FAIL busy_drop: got %0b required 0", busy);
            end
         end
         start = (c == 5 || c == 40 || c == 94 || c == 150 || c == 187 || c == 188);
         tick();
      end
      start = 1'b0;
      n_checks++;
      if (bb_clr !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL back_to_back: got clr=%0b busy=%0b required 1/1", bb_clr, busy);
      end
      n_checks++;
      if (exp_addr != 64 || done_cyc != 187) begin
         n_fail++;
         $display("FAIL busy_start_timing: got reads=%0d done=%0d required 64/187", exp_addr, done_cyc);
      end
   endtask

   task automatic test_small();
      int wins = 0, done_cyc = -1;
      do_reset();
      start5 = 1'b1;
      tick();
      start5 = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         n_checks++;
         if (wv5 !== (c == 12 || c == 24)) begin
            n_fail++;
            $display("FAIL small_win c=%0d: got %0b required %0b", c, wv5, c == 12 || c == 24);
         end
         if (wv5) begin
            wins++;
            n_checks++;
            if (wr5 !== 3'd0) begin
               n_fail++; $display("FAIL small_win_row: got %0d required 0", wr5);
            end
         end
         if (done5 && done_cyc < 0) done_cyc = c;
         tick();
      end
      n_checks++;
      if (wins != 2 || done_cyc != 25) begin
         n_fail++;
         $display("FAIL small_frame: got wins=%0d done=%0d required 2/25", wins, done_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_reset_mid();
      test_start_while_busy();
      test_small();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bankbuff_feeder.md
# bankbuff_feeder

Row sequencer that fills the bank buffer from the image SRAM and hands completed vertical windows to the MAC array. It reads one `BB_REG_WIDTH*FXP` row segment per image row, pushes it into the bank buffer shift chain with `en`, and selects the zero-padding side with `roi_lb_r`. It processes the left strip, then the right strip, clearing the buffer between strips. A `win_valid`/`win_ready` handshake holds the buffer still while the MAC consumes each window.

## Interface
- `FXP`, 6: bits per pixel value
- `BB_REG_WIDTH`, 36: pixels per row segment (32 + 4 overlap)
- `MAC_CN_HGT`, 5: filter height, which is also the bank buffer depth
- `IMG_ROWS`, 32: image rows per strip; must be >= `MAC_CN_HGT`
- `ADDR_W`, 10: SRAM address width
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  begin a frame; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  one-cycle pulse when the frame completes
- `mem_rd_en`  out  1  SRAM read strobe
- `mem_addr`  out  ADDR_W  SRAM row address = `strip*IMG_ROWS + row`
- `mem_rd_data`  in  BB_REG_WIDTH*FXP  SRAM read data, valid exactly 1 cycle after `mem_rd_en`
- `bb_en`  out  1  bank buffer shift enable
- `bb_clr`  out  1  bank buffer clear
- `bb_val_in`  out  BB_REG_WIDTH*FXP  row pushed into the bank buffer
- `bb_roi_lb_r`  out  1  strip select: 0 = left (pad on left), 1 = right (pad on right)
- `win_valid`  out  1  bank buffer output holds a complete window
- `win_ready`  in  1  MAC has consumed the window
- `win_row`  out  clog2(IMG_ROWS)  image row index of the window's top row

## Operation
- **States:** IDLE, CLR, RD, PUSH, WIN, DONE.
- **IDLE:**
  - When `start`=1: go to CLR, set `strip`=0 and `row`=0.
  - Otherwise `start` is ignored.
- **CLR:**
  - `bb_clr`=1 for one cycle.
  - Reset the pushed-row counter `cnt` to 0.
  - Go to RD.
- **RD:**
  - `mem_rd_en`=1 and `mem_addr`=`strip*IMG_ROWS+row`.
  - Go to PUSH.
- **PUSH:**
  - `bb_en`=1 and `bb_val_in`=`mem_rd_data`; this is a combinational pass-through and is zero outside PUSH.
  - Increment `cnt`, saturating at `MAC_CN_HGT`.
  - If the incremented `cnt` equals `MAC_CN_HGT`, go to WIN.
  - Else increment `row` and go to RD.
- **WIN:**
  - `win_valid`=1 and `win_row`=`row-MAC_CN_HGT+1`. `bb_en` and `bb_clr` stay 0, so the window is frozen.
  - On `win_ready`=1:
    - If `row`<`IMG_ROWS-1`: increment `row` and go to RD.
    - Else if `strip`=0: set `strip`=1, `row`=0, and go to CLR.
    - Else go to DONE.
  - If `win_ready` stays 0, remain in WIN indefinitely with all outputs stable.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **`bb_roi_lb_r`:** equals the registered `strip` value. It changes only on the CLR entry edge, never mid-strip.
- **Window count:** `IMG_ROWS-MAC_CN_HGT+1` windows per strip, with `win_row` running 0 .. `IMG_ROWS-MAC_CN_HGT` in order.
- **`win_ready` outside WIN:** ignored.
- **`start` while busy:** ignored; it is not queued.

## Timing
- **Reset:** `rst_n`=0 at an edge forces IDLE, `strip`=0, `row`=0, `cnt`=0. All outputs read 0 from that edge (`busy`, `done`, `mem_rd_en`, `mem_addr`, `bb_en`, `bb_clr`, `bb_val_in`, `bb_roi_lb_r`, `win_valid`, `win_row`). This applies mid-frame as well; no partial-frame `done` is produced.
- **Read latency:** 1 cycle from RD to PUSH. `mem_rd_data` is sampled only in PUSH.
- **Per-row cost:** 2 cycles, plus 1 cycle minimum in WIN once the buffer is primed.
- **Per-strip cost with `win_ready` tied high:** 1 + 2·`IMG_ROWS` + (`IMG_ROWS-MAC_CN_HGT+1`) cycles. With defaults this is 93 cycles.
- **Frame timing with defaults:** the CLR cycle is cycle 1 after the `start` edge, and `done` pulses in cycle 187.
- **First window:** `win_valid` first rises the cycle after the `MAC_CN_HGT`-th PUSH, with `win_row`=0.
- **`busy`:** low again in the cycle after DONE. A new `start` can be accepted in that same cycle.

## Test plan
- **Full frame, `win_ready` tied 1, defaults:**
  - 28 `win_valid` cycles with `bb_roi_lb_r`=0 and `win_row` 0..27.
  - Then one `bb_clr`, then 28 more windows with `bb_roi_lb_r`=1.
  - `done` pulses exactly at cycle 187.
- **SRAM model returns `{strip,row}` as the data pattern:**
  - Every PUSH drives `bb_val_in` equal to the addressed row.
  - Addresses run 0..31, then 32..63, each exactly once.
- **Backpressure:**
  - Hold `win_ready`=0 for 10 cycles at window `win_row`=3; `win_valid`, `win_row`, `bb_en`=0 and `mem_rd_en`=0 stay stable for all 10 cycles.
  - Release; the next RD addresses row 8.
- **Reset at cycle 50 mid-strip:**
  - All outputs are 0 on the next cycle and `done` never pulses.
  - A new `start` restarts at address 0 with `bb_clr`=1.
- **`start` pulsed while busy, and `win_ready`=1 outside WIN:**
  - No effect; the address sequence and `done` timing are unchanged.
- **`IMG_ROWS`=`MAC_CN_HGT`=5:**
  - Exactly one window per strip, with `win_row`=0.
  - `done` at cycle 2·(1+10+1)+1 = 25.
